// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the decode-stage hazard/stall controller.
// Optional feature macro: HAZARD_PERF_EN (performance counters, see top).
package hazard_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL1 = 2'd1,
        STALL2 = 2'd2
    } state_t;

    // Number of stall cycles a hazard in decode requires.
    typedef enum logic [1:0] {
        NEED_NONE  = 2'd0,
        NEED_ONE   = 2'd1,
        NEED_TWO   = 2'd2,
        NEED_THREE = 2'd3
    } need_t;

    // Architectural zero register; writes to it never create a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle of decode/EX/MEM status inputs and pipeline control outputs of the
// hazard/stall controller. The master drives pipeline status; the slave is
// the controller.
interface hazard_stall_unit_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
);
    logic [REG_W-1:0] IF_ID_RS;
    logic [REG_W-1:0] IF_ID_RT;
    logic             IF_ID_USES_RT;
    logic             IF_ID_BRANCH;
    logic             ID_EX_MEMREAD;
    logic             ID_EX_REGWRITE;
    logic [REG_W-1:0] ID_EX_WREG;
    logic             EX_MEM_MEMREAD;
    logic [REG_W-1:0] EX_MEM_RD;
    logic             BRANCH_TAKEN;
    logic             JUMP;
    logic             MEM_BUSY;
    logic             PC_WRITE;
    logic             IF_ID_WRITE;
    logic             ID_EX_BUBBLE;
    logic             IF_ID_FLUSH;
    logic [CNT_W-1:0] STALL_CYCLES;
    logic [CNT_W-1:0] FLUSH_COUNT;

    modport master (
        output IF_ID_RS, IF_ID_RT, IF_ID_USES_RT, IF_ID_BRANCH,
               ID_EX_MEMREAD, ID_EX_REGWRITE, ID_EX_WREG,
               EX_MEM_MEMREAD, EX_MEM_RD, BRANCH_TAKEN, JUMP, MEM_BUSY,
        input  PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE, IF_ID_FLUSH,
               STALL_CYCLES, FLUSH_COUNT
    );

    modport slave (
        input  IF_ID_RS, IF_ID_RT, IF_ID_USES_RT, IF_ID_BRANCH,
               ID_EX_MEMREAD, ID_EX_REGWRITE, ID_EX_WREG,
               EX_MEM_MEMREAD, EX_MEM_RD, BRANCH_TAKEN, JUMP, MEM_BUSY,
        output PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE, IF_ID_FLUSH,
               STALL_CYCLES, FLUSH_COUNT
    );
endinterface

// File: rtl/hazard_stall_unit_detect.sv
// Combinational hazard classifier: decides how many stall cycles the
// instruction in decode needs given the producers in EX and MEM.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             if_id_branch,
    input  logic             id_ex_memread,
    input  logic             id_ex_regwrite,
    input  logic [REG_W-1:0] id_ex_wreg,
    input  logic             ex_mem_memread,
    input  logic [REG_W-1:0] ex_mem_rd,
    output need_t            need
);

    logic ex_match;
    logic mem_match;

    // Producer register matches a source the decode instruction actually reads.
    always_comb begin
        ex_match  = (id_ex_wreg != REG_W'(REG_ZERO)) &&
                    ((id_ex_wreg == if_id_rs) || (if_id_uses_rt && (id_ex_wreg == if_id_rt)));
        mem_match = (ex_mem_rd != REG_W'(REG_ZERO)) &&
                    ((ex_mem_rd == if_id_rs) || (if_id_uses_rt && (ex_mem_rd == if_id_rt)));
    end

    // Prioritised rules: branches resolve in decode so they wait longer.
    always_comb begin
        need = NEED_NONE;
        if (if_id_branch) begin
            if (id_ex_memread && ex_match) begin
                need = NEED_TWO;
            end else if (id_ex_regwrite && ex_match) begin
                need = NEED_ONE;
            end else if (ex_mem_memread && mem_match) begin
                need = NEED_ONE;
            end
        end else if (id_ex_memread && ex_match) begin
            need = NEED_ONE;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: stalls PC and IF/ID, injects ID/EX bubbles,
// flushes IF/ID on taken branches/jumps and freezes on MEM_BUSY.
// Define HAZARD_PERF_EN to build the STALL_CYCLES/FLUSH_COUNT counters;
// otherwise those ports read as zero.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input logic                clk,
    input logic                reset_n,
    hazard_stall_unit_if.slave bus
);

    state_t state_q;
    state_t state_d;
    need_t  need;

    logic pc_write;
    logic if_id_write;
    logic bubble;
    logic flush;
    logic frozen;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_detect (
        .if_id_rs       (bus.IF_ID_RS),
        .if_id_rt       (bus.IF_ID_RT),
        .if_id_uses_rt  (bus.IF_ID_USES_RT),
        .if_id_branch   (bus.IF_ID_BRANCH),
        .id_ex_memread  (bus.ID_EX_MEMREAD),
        .id_ex_regwrite (bus.ID_EX_REGWRITE),
        .id_ex_wreg     (bus.ID_EX_WREG),
        .ex_mem_memread (bus.EX_MEM_MEMREAD),
        .ex_mem_rd      (bus.EX_MEM_RD),
        .need           (need)
    );

    // Mealy output decode and next-state: first stall cycle has zero latency.
    // Reset forces the free-running RUN decode; MEM_BUSY freezes everything.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        bubble      = 1'b0;
        flush       = 1'b0;
        frozen      = 1'b0;
        if (!reset_n) begin
            state_d = RUN;
        end else if (bus.MEM_BUSY) begin
            frozen      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (need == NEED_NONE) begin
                        flush = bus.JUMP || (bus.IF_ID_BRANCH && bus.BRANCH_TAKEN);
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        bubble      = 1'b1;
                        if (need == NEED_TWO) begin
                            state_d = STALL1;
                        end else if (need == NEED_THREE) begin
                            state_d = STALL2;
                        end
                    end
                end
                STALL1: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    bubble      = 1'b1;
                    state_d     = RUN;
                end
                STALL2: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    bubble      = 1'b1;
                    state_d     = STALL1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.PC_WRITE     = pc_write;
    assign bus.IF_ID_WRITE  = if_id_write;
    assign bus.ID_EX_BUBBLE = bubble;
    assign bus.IF_ID_FLUSH  = flush;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Event counters advance only on non-frozen cycles and wrap naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!frozen) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(bubble);
            flush_cnt_d = flush_cnt_q + CNT_W'(flush);
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.STALL_CYCLES = stall_cnt_q;
    assign bus.FLUSH_COUNT  = flush_cnt_q;
`else
    logic unused_frozen;
    assign unused_frozen    = frozen;
    assign bus.STALL_CYCLES = '0;
    assign bus.FLUSH_COUNT  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios followed by
// random traffic, checked against a cycle-count reference model.
module tb_hazard_stall_unit;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    hazard_stall_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: number of forced stall cycles still owed, plus event totals.
    int          pend = 0;
    logic [31:0] stall_m = '0;
    logic [31:0] flush_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((r == bus.IF_ID_RS) || (bus.IF_ID_USES_RT && r == bus.IF_ID_RT));
    endfunction

    function automatic int need_of();
        if (bus.IF_ID_BRANCH) begin
            if (bus.ID_EX_MEMREAD && reads(bus.ID_EX_WREG)) return 2;
            if (bus.ID_EX_REGWRITE && reads(bus.ID_EX_WREG)) return 1;
            if (bus.EX_MEM_MEMREAD && reads(bus.EX_MEM_RD)) return 1;
            return 0;
        end
        if (bus.ID_EX_MEMREAD && reads(bus.ID_EX_WREG)) return 1;
        return 0;
    endfunction

    // Inputs are set at the falling edge; check outputs, then advance one cycle.
    task automatic step(input string tag);
        logic ep, ei, eb, ef;
        int n;
        #1;
        n = 0;
        if (!reset_n) begin
            ep = 1; ei = 1; eb = 0; ef = 0;
        end else if (bus.MEM_BUSY) begin
            ep = 0; ei = 0; eb = 0; ef = 0;
        end else if (pend > 0) begin
            ep = 0; ei = 0; eb = 1; ef = 0;
        end else begin
            n = need_of();
            if (n > 0) begin
                ep = 0; ei = 0; eb = 1; ef = 0;
            end else begin
                ep = 1; ei = 1; eb = 0;
                ef = bus.JUMP || (bus.IF_ID_BRANCH && bus.BRANCH_TAKEN);
            end
        end
        chk({tag, ".pc_write"}, 32'(bus.PC_WRITE), 32'(ep));
        chk({tag, ".if_id_write"}, 32'(bus.IF_ID_WRITE), 32'(ei));
        chk({tag, ".bubble"}, 32'(bus.ID_EX_BUBBLE), 32'(eb));
        chk({tag, ".flush"}, 32'(bus.IF_ID_FLUSH), 32'(ef));
`ifdef HAZARD_PERF_EN
        chk({tag, ".stall_cycles"}, bus.STALL_CYCLES, stall_m);
        chk({tag, ".flush_count"}, bus.FLUSH_COUNT, flush_m);
`else
        chk({tag, ".stall_cycles"}, bus.STALL_CYCLES, 32'd0);
        chk({tag, ".flush_count"}, bus.FLUSH_COUNT, 32'd0);
`endif
        if (!reset_n) begin
            pend = 0; stall_m = '0; flush_m = '0;
        end else if (!bus.MEM_BUSY) begin
            if (pend > 0) pend--;
            else if (n > 0) pend = n - 1;
            stall_m += 32'(eb);
            flush_m += 32'(ef);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear();
        bus.IF_ID_RS = '0; bus.IF_ID_RT = '0; bus.IF_ID_USES_RT = 0; bus.IF_ID_BRANCH = 0;
        bus.ID_EX_MEMREAD = 0; bus.ID_EX_REGWRITE = 0; bus.ID_EX_WREG = '0;
        bus.EX_MEM_MEMREAD = 0; bus.EX_MEM_RD = '0; bus.BRANCH_TAKEN = 0;
        bus.JUMP = 0; bus.MEM_BUSY = 0;
    endtask

    // lw $t0 in EX, beq $t0,$t1 (taken) in ID
    task automatic lw_beq();
        clear();
        bus.ID_EX_MEMREAD = 1; bus.ID_EX_REGWRITE = 1; bus.ID_EX_WREG = 5'd8;
        bus.IF_ID_BRANCH = 1; bus.IF_ID_USES_RT = 1; bus.IF_ID_RS = 5'd8; bus.IF_ID_RT = 5'd9;
        bus.BRANCH_TAKEN = 1;
    endtask

    initial begin
        clear();
        @(negedge clk);
        reset_n = 0;
        step("rst0");
        step("rst1");
        reset_n = 1;
        step("idle");

        // load-use on a non-branch
        clear();
        bus.ID_EX_MEMREAD = 1; bus.ID_EX_REGWRITE = 1; bus.ID_EX_WREG = 5'd8;
        bus.IF_ID_RS = 5'd8; bus.IF_ID_RT = 5'd10; bus.IF_ID_USES_RT = 1;
        step("lu.stall");
        bus.ID_EX_MEMREAD = 0; bus.ID_EX_REGWRITE = 0; bus.ID_EX_WREG = '0;
        step("lu.free");

        // load then branch: two stalls then flush
        reset_n = 0;
        step("rst2");
        reset_n = 1;
        lw_beq();
        step("lb.s1");
        bus.ID_EX_MEMREAD = 0; bus.ID_EX_REGWRITE = 0; bus.ID_EX_WREG = '0;
        bus.EX_MEM_MEMREAD = 1; bus.EX_MEM_RD = 5'd8;
        step("lb.s2");
        bus.EX_MEM_MEMREAD = 0; bus.EX_MEM_RD = '0;
        step("lb.flush");
`ifdef HAZARD_PERF_EN
        chk("lb.stall_total", bus.STALL_CYCLES, 32'd2);
        chk("lb.flush_total", bus.FLUSH_COUNT, 32'd1);
`endif

        // $0 never hazards; unused rt never hazards
        clear();
        bus.ID_EX_REGWRITE = 1; bus.ID_EX_WREG = 5'd0; bus.IF_ID_RS = 5'd0;
        bus.IF_ID_USES_RT = 1; bus.IF_ID_BRANCH = 1;
        step("zero.br");
        clear();
        bus.ID_EX_MEMREAD = 1; bus.ID_EX_WREG = 5'd5; bus.IF_ID_RS = 5'd3; bus.IF_ID_RT = 5'd5;
        step("rt.unused");

        // jump flushes; untaken branch does not
        clear();
        bus.JUMP = 1;
        step("jump");
        clear();
        bus.IF_ID_BRANCH = 1; bus.IF_ID_RS = 5'd4;
        step("br.nt");

        // MEM_BUSY during STALL1
        lw_beq();
        step("busy.s1");
        bus.ID_EX_MEMREAD = 0; bus.ID_EX_REGWRITE = 0; bus.ID_EX_WREG = '0;
        bus.MEM_BUSY = 1;
        for (int i = 0; i < 3; i++) step("busy.hold");
        bus.MEM_BUSY = 0;
        step("busy.s2");
        step("busy.done");

        // reset abandons a two-cycle stall
        lw_beq();
        step("rstab.s1");
        reset_n = 0;
        step("rstab.rst");
        reset_n = 1;
        clear();
        step("rstab.run");

        // random traffic over a small register set to provoke matches
        for (int i = 0; i < 600; i++) begin
            bus.IF_ID_RS       = 5'($urandom_range(0, 3));
            bus.IF_ID_RT       = 5'($urandom_range(0, 3));
            bus.IF_ID_USES_RT  = 1'($urandom);
            bus.IF_ID_BRANCH   = 1'($urandom);
            bus.ID_EX_MEMREAD  = ($urandom_range(0, 2) == 0);
            bus.ID_EX_REGWRITE = 1'($urandom);
            bus.ID_EX_WREG     = 5'($urandom_range(0, 3));
            bus.EX_MEM_MEMREAD = ($urandom_range(0, 2) == 0);
            bus.EX_MEM_RD      = 5'($urandom_range(0, 3));
            bus.BRANCH_TAKEN   = 1'($urandom);
            bus.JUMP           = ($urandom_range(0, 5) == 0);
            bus.MEM_BUSY       = ($urandom_range(0, 7) == 0);
            reset_n            = ($urandom_range(0, 39) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
